key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter TICK_DIV, default 50000, means clocks per timing tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter LONG_TICKS, default 1000, means ticks held before a long-press event; legal range 1..65535.
REQ-003 Parameter DCLICK_TICKS, default 250, means ticks allowed after first release for a second press; legal range 1..65535.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 nCR  input  1  asynchronous active-low reset.
REQ-006 key_level  input  1  debounced key level from the debounce block, same clock domain; 1 = released, 0 = pressed.
REQ-007 pressed  output  1  registered copy of key state; 1 = key currently held.
REQ-008 click_evt  output  1  one-clock pulse; single short click confirmed.
REQ-009 dclick_evt  output  1  one-clock pulse; double click detected.
REQ-010 long_evt  output  1  one-clock pulse; long press reached.
REQ-011 event_count  output  8  count of click, dclick and long events.

Function
REQ-012 Block SHALL register key_level once (prev) and define press edge = prev 1 & key_level 0, release edge = prev 0 & key_level 1.
REQ-013 Tick generator SHALL count 0..TICK_DIV-1 continuously from reset and assert tick for one clock when count = TICK_DIV-1.
REQ-014 Tick timer SHALL be 16 bits, clear on every state transition, increment on tick, and saturate at 65535.
REQ-015 FSM states SHALL be IDLE, PRESS1, LONG, WAIT2 and PRESS2.
REQ-016 IDLE: press edge -> PRESS1.
REQ-017 PRESS1: release edge -> WAIT2.
REQ-018 PRESS1: otherwise, timer = LONG_TICKS on tick -> LONG, with long_evt asserted for that clock.
REQ-019 LONG: release edge -> IDLE with no event.
REQ-020 WAIT2: press edge -> PRESS2, with dclick_evt asserted for that clock.
REQ-021 WAIT2: otherwise, timer = DCLICK_TICKS on tick -> IDLE, with click_evt asserted for that clock.
REQ-022 PRESS2: release edge -> IDLE with no event.
REQ-023 Simultaneous release edge and long expiry in PRESS1 SHALL take the release path, producing no long_evt.
REQ-024 Simultaneous press edge and window expiry in WAIT2 SHALL take the press path, producing dclick_evt only.
REQ-025 At most one event pulse SHALL be asserted in any clock; event outputs SHALL be registered, one clock after the causing edge or tick.
REQ-026 event_count SHALL increment by 1 on each event pulse and wrap 255 -> 0.
REQ-027 pressed SHALL equal the inverse of prev.

Reset
REQ-028 nCR low SHALL immediately force: FSM IDLE, prev 1, timer 0, tick counter 0, pressed 0, all event pulses 0, event_count 0.
REQ-029 Reset mid-press SHALL emit no event, and a key still held when reset releases SHALL not register a press until released and pressed again.

Structure
REQ-030 Package key_event_pkg SHALL hold the FSM state encoding and the default constants for TICK_DIV, LONG_TICKS and DCLICK_TICKS.
REQ-031 Tick generation SHALL be a sub-module tick_gen (ports clk, nCR, tick; parameter TICK_DIV), reusable by the debounce block.

Verification
Benches SHALL run with TICK_DIV=4, LONG_TICKS=10, DCLICK_TICKS=5.
REQ-032 Press 12 clk, release, idle 40 clk -> single click_evt about 20 clk after release; event_count=1.
REQ-033 Press 60 clk -> long_evt once near clk 40 of hold; release -> no further event; event_count=1.
REQ-034 Press 8, release 8, press 8, release -> dclick_evt one clk after second press edge; no click_evt; event_count=1.
REQ-035 Release edge coincident with long-expiry tick -> no long_evt; click_evt after window expiry.
REQ-036 256 single clicks -> event_count wraps to 0.
REQ-037 nCR low during PRESS1 while key held, then released -> all outputs 0; no event until next full press.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder: FSM encoding and default timing constants.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } key_state_e;

  localparam int unsigned TICK_DIV_DEF     = 50000;
  localparam int unsigned LONG_TICKS_DEF   = 1000;
  localparam int unsigned DCLICK_TICKS_DEF = 250;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-clock tick every TICK_DIV clocks, phase fixed by reset.
module tick_gen #(
  parameter int unsigned TICK_DIV = key_event_pkg::TICK_DIV_DEF
) (
  input  logic clk,
  input  logic nCR,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR)             cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into click / double-click / long-press pulses plus an event counter.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF,
  parameter int unsigned DCLICK_TICKS = DCLICK_TICKS_DEF
) (
  input  logic       clk,
  input  logic       nCR,
  input  logic       key_level,
  output logic       pressed,
  output logic       click_evt,
  output logic       dclick_evt,
  output logic       long_evt,
  output logic [7:0] event_count
);

  localparam logic [15:0] LONG_T  = 16'(LONG_TICKS);
  localparam logic [15:0] DCLK_T  = 16'(DCLICK_TICKS);
  localparam logic [15:0] TMR_MAX = 16'hFFFF;

  logic       tick;
  logic       prev;
  logic       armed;
  logic       press_edge;
  logic       release_edge;
  logic [15:0] timer;
  key_state_e state;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .nCR  (nCR),
    .tick (tick)
  );

  // A key held through reset leaves armed low, so it cannot start a press
  // until it has been seen released at least once.
  assign press_edge   = prev & ~key_level & armed;
  assign release_edge = ~prev & key_level;

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      state       <= IDLE;
      prev        <= 1'b1;
      armed       <= 1'b0;
      pressed     <= 1'b0;
      timer       <= '0;
      click_evt   <= 1'b0;
      dclick_evt  <= 1'b0;
      long_evt    <= 1'b0;
      event_count <= '0;
    end else begin
      prev       <= key_level;
      pressed    <= ~key_level;
      click_evt  <= 1'b0;
      dclick_evt <= 1'b0;
      long_evt   <= 1'b0;
      if (key_level) armed <= 1'b1;
      if (tick && timer != TMR_MAX) timer <= timer + 16'd1;

      // Every transition below also clears the timer, overriding the increment.
      case (state)
        IDLE: begin
          if (press_edge) begin
            state <= PRESS1;
            timer <= '0;
          end
        end
        PRESS1: begin
          if (release_edge) begin
            state <= WAIT2;
            timer <= '0;
          end else if (tick && timer == LONG_T) begin
            state       <= LONG;
            timer       <= '0;
            long_evt    <= 1'b1;
            event_count <= event_count + 8'd1;
          end
        end
        LONG: begin
          if (release_edge) begin
            state <= IDLE;
            timer <= '0;
          end
        end
        WAIT2: begin
          if (press_edge) begin
            state       <= PRESS2;
            timer       <= '0;
            dclick_evt  <= 1'b1;
            event_count <= event_count + 8'd1;
          end else if (tick && timer == DCLK_T) begin
            state       <= IDLE;
            timer       <= '0;
            click_evt   <= 1'b1;
            event_count <= event_count + 8'd1;
          end
        end
        PRESS2: begin
          if (release_edge) begin
            state <= IDLE;
            timer <= '0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scenario-table bench for key_event_decoder; expected events are queued at stimulus time.
module tb_key_event_decoder;

  localparam int TD = 4;
  localparam int LT = 10;
  localparam int DT = 5;

  logic       clk = 1'b0;
  logic       nCR = 1'b0;
  logic       key_level = 1'b1;
  logic       pressed, click_evt, dclick_evt, long_evt;
  logic [7:0] event_count;

  key_event_decoder #(.TICK_DIV(TD), .LONG_TICKS(LT), .DCLICK_TICKS(DT)) dut (
    .clk         (clk),
    .nCR         (nCR),
    .key_level   (key_level),
    .pressed     (pressed),
    .click_evt   (click_evt),
    .dclick_evt  (dclick_evt),
    .long_evt    (long_evt),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_NONE = 0, EV_CLICK = 1, EV_DCLICK = 2, EV_LONG = 3} ev_e;
  typedef struct { ev_e kind; int cyc; logic [7:0] cnt; } exp_t;
  typedef struct { int a; int b; int c; ev_e k0; ev_e k1; } vec_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc;
  logic [7:0] exp_cnt = 8'd0;
  ev_e        mon_got;
  exp_t       mon_e;
  vec_t       tbl[9];

  // Posedge index since reset release; outputs registered at posedge N are seen at the negedge with cyc == N.
  always @(posedge clk or negedge nCR)
    if (!nCR) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (nCR === 1'b1 && (click_evt === 1'b1 || dclick_evt === 1'b1 || long_evt === 1'b1)) begin
      mon_got = click_evt ? EV_CLICK : (dclick_evt ? EV_DCLICK : EV_LONG);
      chk("one_pulse", 32'(click_evt) + 32'(dclick_evt) + 32'(long_evt), 1);
      if (sbq.size() == 0) begin
        chk("unexpected_evt", int'(mon_got), int'(EV_NONE));
      end else begin
        mon_e = sbq.pop_front();
        chk("evt_kind", int'(mon_got), int'(mon_e.kind));
        chk("evt_cycle", cyc, mon_e.cyc);
        chk("evt_count", event_count, mon_e.cnt);
      end
    end
  end

  function automatic int tick_after(input int c, input int n);
    return ((c / TD) + n) * TD;
  endfunction

  task automatic push(input ev_e k, input int c, inout int last);
    if (k != EV_NONE) begin
      exp_cnt = exp_cnt + 8'd1;
      sbq.push_back('{k, c, exp_cnt});
      if (c > last) last = c;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pressed"}, pressed, 0);
    chk({tag, "_click"},   click_evt, 0);
    chk({tag, "_dclick"},  dclick_evt, 0);
    chk({tag, "_long"},    long_evt, 0);
    chk({tag, "_count"},   event_count, 0);
  endtask

  task automatic do_reset();
    nCR = 1'b0;
    repeat (3) @(negedge clk);
    nCR = 1'b1;
    exp_cnt = 8'd0;
    sbq.delete();
  endtask

  // Press a clocks, gap b, optional second press c clocks; events computed from tick phase.
  task automatic run(input int a, input int b, input int c, input ev_e k0, input ev_e k1);
    int p, r, p2, lng, win, last, nx;
    while (cyc % TD != 0 || cyc == 0) @(negedge clk);
    p    = cyc + 1;
    r    = p + a;
    p2   = r + b;
    lng  = tick_after(p, LT + 1);
    last = (c > 0) ? p2 + c : r;
    if (r > lng) begin
      push(k0, lng, last);
    end else begin
      win = tick_after(r, DT + 1);
      if (win > last) last = win;
      if (c == 0)        push(k0, win, last);
      else if (p2 <= win) push(k0, p2, last);
      else begin
        push(k0, win, last);
        push(k1, tick_after(p2 + c, DT + 1), last);
      end
    end
    while (cyc < last + 3) begin
      nx = cyc + 1;
      key_level = !((nx >= p && nx < r) || (c > 0 && nx >= p2 && nx < p2 + c));
      @(negedge clk);
    end
    chk("queue_drained", sbq.size(), 0);
    chk("count_idle", event_count, exp_cnt);
    chk("pressed_idle", pressed, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{12, 0,  0, EV_CLICK,  EV_NONE};   // plain click
    tbl[1] = '{60, 0,  0, EV_LONG,   EV_NONE};   // long press
    tbl[2] = '{ 8, 8,  8, EV_DCLICK, EV_NONE};   // double click
    tbl[3] = '{ 1, 0,  0, EV_CLICK,  EV_NONE};   // one-clock press
    tbl[4] = '{43, 0,  0, EV_CLICK,  EV_NONE};   // release on long-expiry tick
    tbl[5] = '{44, 0,  0, EV_LONG,   EV_NONE};   // release one clock too late
    tbl[6] = '{ 8, 23, 4, EV_DCLICK, EV_NONE};   // second press on window-expiry tick
    tbl[7] = '{ 8, 24, 5, EV_CLICK,  EV_CLICK};  // second press just after window
    tbl[8] = '{20, 2, 30, EV_DCLICK, EV_NONE};   // long second press gives no long

    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 9; i++) begin
      if (i == 0 || i == 1 || i == 2) begin
        do_reset();
        chk_zero("prescenario");
      end
      run(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].k0, tbl[i].k1);
    end

    // Reset while held in PRESS1; key stays down after reset, then releases.
    while (cyc % TD != 0 || cyc == 0) @(negedge clk);
    key_level = 1'b0;
    repeat (10) @(negedge clk);
    #2 nCR = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(negedge clk);
    nCR = 1'b1;
    exp_cnt = 8'd0;
    repeat (60) @(negedge clk);
    chk("held_pressed", pressed, 1);
    chk("held_count", event_count, 0);
    key_level = 1'b1;
    repeat (40) @(negedge clk);
    chk_zero("after_held");
    chk("held_queue", sbq.size(), 0);
    run(12, 0, 0, EV_CLICK, EV_NONE);
    chk("first_after_reset", event_count, 1);

    // 256 clicks from a clean count wrap back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) run(2, 0, 0, EV_CLICK, EV_NONE);
    chk("count_wrap", event_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
